// File: rtl/if_fetch.sv
// Byte-serial instruction fetch stage: assembles a 32-bit little-endian word
// from four single-byte memory reads and presents it to the IF/ID register.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rdy_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stallreq_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  k;
    logic [31:0] pc;
    logic [31:0] fetch_buf;

    logic [1:0]  k_next;
    logic [31:0] branch_pc;

    assign k_next    = k + 2'd1;
    assign branch_pc = {branch_target_i[31:2], 2'b00};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 2'd0;
            pc         <= 32'd0;
            fetch_buf  <= 32'd0;
            inst_o     <= 32'd0;
            pc_o       <= 32'd0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'd0;
            stallreq_o <= 1'b0;
        end else if (branch_flag_i) begin
            // A redirect wins in every state, including over a completing byte.
            state      <= FETCH;
            k          <= 2'd0;
            pc         <= branch_pc;
            fetch_buf  <= 32'd0;
            inst_o     <= 32'd0;
            pc_o       <= 32'd0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= branch_pc;
            stallreq_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    k          <= 2'd0;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= pc;
                    stallreq_o <= 1'b1;
                end
                FETCH: begin
                    if (mem_rdy_i) begin
                        fetch_buf[{k, 3'b000} +: 8] <= mem_rdata_i;
                        k <= k_next;
                        if (k == 2'd3) begin
                            inst_o     <= {mem_rdata_i, fetch_buf[23:0]};
                            pc_o       <= pc;
                            mem_req_o  <= 1'b0;
                            stallreq_o <= 1'b0;
                            state      <= DONE;
                        end else begin
                            mem_addr_o <= pc + {30'd0, k_next};
                        end
                    end
                end
                DONE: begin
                    if (!stall[0]) begin
                        pc         <= pc + 32'd4;
                        state      <= FETCH;
                        k          <= 2'd0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc + 32'd4;
                        stallreq_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch: cold start, wait states, branches,
// DONE hold, PC wrap and reset during a fetch.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rdy_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stallreq_o;

    int vectors;
    int miscompares;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdy_i      (mem_rdy_i),
        .mem_rdata_i    (mem_rdata_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .stallreq_o     (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'waits' idle cycles, checking the request stays stable.
    task automatic give_byte(input string name, input logic [31:0] exp_addr,
                             input logic [7:0] data, input int waits);
        for (int w = 0; w <= waits; w++) begin
            vectors++;
            if (mem_addr_o !== exp_addr || mem_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
                miscompares++;
                $display("FAIL %s: addr=%h req=%b stallreq=%b, expected addr=%h req=1 stallreq=1",
                         name, mem_addr_o, mem_req_o, stallreq_o, exp_addr);
            end
            if (w < waits) tick();
        end
        mem_rdy_i   = 1'b1;
        mem_rdata_i = data;
        tick();
        mem_rdy_i   = 1'b0;
        mem_rdata_i = 8'h00;
    endtask

    // Fetch a whole word at base and check the DONE-cycle outputs.
    task automatic fetch_word(input string name, input logic [31:0] base,
                              input logic [31:0] word, input int waits);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < 4; i++)
            give_byte(name, base + 32'(i), w[8*i +: 8], waits);
        vectors++;
        if (inst_o !== word || pc_o !== base || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: inst=%h pc=%h stallreq=%b req=%b, expected inst=%h pc=%h stallreq=0 req=0",
                     name, inst_o, pc_o, stallreq_o, mem_req_o, word, base);
        end
    endtask

    task automatic check_next_addr(input string name, input logic [31:0] exp_addr);
        vectors++;
        if (mem_addr_o !== exp_addr || mem_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: addr=%h req=%b stallreq=%b, expected addr=%h req=1 stallreq=1",
                     name, mem_addr_o, mem_req_o, stallreq_o, exp_addr);
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'd0 || pc_o !== 32'd0 ||
            inst_o !== 32'd0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: req=%b addr=%h pc=%h inst=%h stallreq=%b, expected all zero",
                     name, mem_req_o, mem_addr_o, pc_o, inst_o, stallreq_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();
        check_next_addr("reset_release", 32'd0);
    endtask

    task automatic test_cold_start();
        fetch_word("cold_start", 32'd0, 32'h0050_0513, 0);
        tick();
        check_next_addr("cold_next", 32'd4);
    endtask

    task automatic test_wait_states();
        fetch_word("wait_states", 32'd4, 32'h0050_0513, 3);
        tick();
        check_next_addr("wait_next", 32'd8);
    endtask

    task automatic test_mid_fetch_branch();
        give_byte("br_partial", 32'd8, 8'hAA, 0);
        give_byte("br_partial", 32'd9, 8'hBB, 0);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0103;
        tick();
        branch_flag_i   = 1'b0;
        check_next_addr("br_redirect", 32'h0000_0100);
        vectors++;
        if (inst_o !== 32'd0 || pc_o !== 32'd0) begin
            miscompares++;
            $display("FAIL br_clear: inst=%h pc=%h, expected 0 and 0", inst_o, pc_o);
        end
        fetch_word("br_refetch", 32'h0000_0100, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_hold_done();
        stall = 6'b000001;
        for (int i = 0; i < 5; i++) begin
            // A stray ready pulse in DONE must be ignored.
            mem_rdy_i   = (i == 2);
            mem_rdata_i = 8'h55;
            tick();
            vectors++;
            if (pc_o !== 32'h100 || inst_o !== 32'hDEAD_BEEF || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_done: pc=%h inst=%h req=%b stallreq=%b, expected pc=00000100 inst=deadbeef req=0 stallreq=0",
                         pc_o, inst_o, mem_req_o, stallreq_o);
            end
        end
        mem_rdy_i   = 1'b0;
        mem_rdata_i = 8'h00;
        stall = 6'b000000;
        tick();
        check_next_addr("hold_release", 32'h0000_0104);
    endtask

    task automatic test_wrap();
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        tick();
        branch_flag_i   = 1'b0;
        check_next_addr("wrap_branch", 32'hFFFF_FFFC);
        fetch_word("wrap_fetch", 32'hFFFF_FFFC, 32'h1234_5678, 1);
        tick();
        check_next_addr("wrap_next", 32'h0000_0000);
    endtask

    task automatic test_branch_on_last_byte();
        give_byte("last_br", 32'd0, 8'h11, 0);
        give_byte("last_br", 32'd1, 8'h22, 0);
        give_byte("last_br", 32'd2, 8'h33, 0);
        mem_rdy_i       = 1'b1;
        mem_rdata_i     = 8'h44;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0200;
        tick();
        mem_rdy_i     = 1'b0;
        branch_flag_i = 1'b0;
        check_next_addr("last_br_redirect", 32'h0000_0200);
        vectors++;
        if (inst_o !== 32'd0 || pc_o !== 32'd0) begin
            miscompares++;
            $display("FAIL last_br_drop: inst=%h pc=%h, expected 0 and 0", inst_o, pc_o);
        end
    endtask

    task automatic test_reset_mid_fetch();
        give_byte("rst_mid", 32'h200, 8'h01, 0);
        give_byte("rst_mid", 32'h201, 8'h02, 0);
        give_byte("rst_mid", 32'h202, 8'h03, 0);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid_zero");
        rst = 1'b0;
        tick();
        check_next_addr("rst_mid_restart", 32'd0);
        fetch_word("rst_refetch", 32'd0, 32'hCAFE_F00D, 0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        stall           = 6'd0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;
        mem_rdy_i       = 1'b0;
        mem_rdata_i     = 8'd0;
        #1;
        test_reset();
        test_cold_start();
        test_wait_states();
        test_mid_fetch_branch();
        test_hold_done();
        test_wrap();
        test_branch_on_last_byte();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
